pwm_ramp: RTL and testbench
===========================

# pwm_ramp

Closed-loop duty-cycle sequencer for the PWM path. Accepts a target duty and steps the `pwm_out` generator toward it in bounded increments, pulsing `update` per step. After each step it waits for the `pwm_in` measurer to report a duty within tolerance before the next step. Sits between control logic and the `pwm_out`/`pwm_in` pair and reports completion or a timeout error.

## Interface
- `STEP`, 8'd4: maximum duty change per step (1..255).
- `TOL`, 8'd2: accepted |measured − commanded| difference.
- `SKIP`, 2: `meas_valid` pulses discarded after each update (stale periods).
- `TIMEOUT`, 24'd2000000: clk cycles allowed per step before error.

Ports:
- `clk`  in  1  system clock.
- `nRst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; latches `target`.
- `target`  in  8  requested final duty.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-cycle pulse: target reached and confirmed.
- `err`  out  1  sticky timeout flag.
- `duty`  out  8  commanded duty to `pwm_out.duty`.
- `update`  out  1  one-cycle load strobe to `pwm_out.update`.
- `meas_valid`  in  1  from `pwm_in.valid`.
- `meas_duty`  in  8  from `pwm_in.duty`.

## Operation
- Reset values: `duty`=0, `update`=0, `busy`=0, `done`=0, `err`=0; state IDLE; internal target, skip and timeout counters 0.
- IDLE: on `start`, latch `target`, clear `err`.
  - If `target`==`duty`: pulse `done` next cycle and stay IDLE.
  - Otherwise set `busy` and go to STEP.
- STEP (one cycle):
  - Compute diff = |tgt − duty| in 9-bit arithmetic.
  - Set `duty` ← `duty` ± min(`STEP`, diff); never overshoot, never wrap past 0/255.
  - Assert `update` for that cycle only; clear the timeout counter; load the skip counter with `SKIP`; go to WAIT.
- WAIT: the timeout counter increments every cycle.
  - While the skip counter is nonzero, each `meas_valid` decrements it and is otherwise ignored.
  - After the skip counter reaches 0, a `meas_valid` with |`meas_duty` − `duty`| ≤ `TOL` (9-bit abs) is accepted.
    - If `duty`==tgt: go to DONE.
    - Otherwise: go to STEP.
  - A `meas_valid` outside tolerance is ignored and the block keeps waiting.
  - When the counter reaches `TIMEOUT`−1 with no accepted sample: set `err`, clear `busy`, go to IDLE. `duty` holds its last value.
- DONE (one cycle): assert `done`, clear `busy`, go to IDLE.
- `start` while `busy` is ignored; the target is not re-latched.
- `meas_valid` in IDLE is ignored.
- If acceptance and timeout occur on the same cycle, acceptance wins.
- `err` stays set until the next accepted `start` or reset.

## Timing
- `start` sampled at edge N → `busy`=1 after N. `duty` new and `update`=1 after N+1. `update`=0 after N+2.
- `duty` is stable for the whole WAIT state; it changes only in the STEP cycle.
- An accepted `meas_valid` at edge M:
  - Next STEP at M+1 (`update` high after M+1), or
  - `done`=1 and `busy`=0 after M+1, `done`=0 after M+2.
- Per-step latency = 1 + time to (`SKIP`+1)th valid measurement.
- Ramp from d0 to d1 takes ceil(|d1−d0|/`STEP`) updates.
- Reset mid-ramp: all outputs return to reset values immediately (asynchronous). `duty`=0 commands the generator off.

## Structure
- Shared package `pwm_pkg`:
  - Duty width localparam (8).
  - State encoding localparams: IDLE, STEP, WAIT, DONE (2 bits).
  - Abs-difference function used by both the step and tolerance logic.
- One natural sub-module: `pwm_timeout`, a loadable up-counter with clear, enable and terminal-count output (width derived from `TIMEOUT`).
- FSM, target register and skip counter live in `pwm_ramp`.

## Test plan
- Ramp up: `duty`=0, `start` with `target`=10, `STEP`=4, bench returns `meas_duty`=`duty` after `SKIP`+1 valids → updates with `duty` 4, 8, 10; one `done` pulse; `err`=0.
- Ramp down with clamp: from 10, `target`=0, `STEP`=4 → `duty` 6, 2, 0; no wrap to 255; `done` pulsed.
- Tolerance: commanded 128, `meas_duty`=130 accepted; `meas_duty`=131 ignored, then 127 accepted → next step issued one cycle later.
- Timeout: no `meas_valid` after the first update, `TIMEOUT`=100 → `err`=1 and `busy`=0 exactly 100 cycles after `update`; `duty` held; the next `start` clears `err`.
- Already at target: `duty`=50, `start` with `target`=50 → no `update`, `done` pulse the cycle after `start`, `busy` never high.
- Disturbance:
  - `start` during a ramp with a different `target` is ignored (final `duty` equals the first target).
  - `nRst` pulsed mid-WAIT → `duty`=0, all flags 0, IDLE.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the PWM ramp sequencer: duty width, FSM state
//   encoding and the 9-bit absolute-difference helper used both when sizing
//   a step and when judging a measurement against the commanded duty.
package pwm_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // |a - b| computed in 9 bits so the result never wraps.
  function automatic logic [DUTY_W:0] abs_diff(input logic [DUTY_W-1:0] a,
                                               input logic [DUTY_W-1:0] b);
    logic [DUTY_W:0] ea;
    logic [DUTY_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/pwm_timeout.sv
// pwm_timeout
//   Loadable up-counter used as the per-step watchdog. Saturates at the
//   terminal count TIMEOUT-1, which is flagged on tc.
// Ports:
//   clk      in   system clock
//   nRst     in   asynchronous active-low reset
//   clr      in   synchronous clear to 0 (highest priority)
//   load     in   synchronous load of load_val
//   load_val in   value loaded when load is high
//   en       in   count enable
//   tc       out  count == TIMEOUT-1
module pwm_timeout #(
  parameter logic [23:0] TIMEOUT = 24'd2000000,
  parameter int          CW      = (TIMEOUT > 24'd1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 24'd1);

  logic [CW-1:0] count_reg;

  assign tc = (count_reg == TC_VAL);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && !tc) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp.sv
// pwm_ramp
//   Closed-loop duty sequencer. Steps the commanded duty toward a latched
//   target by at most STEP per update, and after each update waits for a
//   fresh measurement (the first SKIP valids are stale) within TOL before
//   stepping again. A step that sees no acceptable sample within TIMEOUT
//   cycles aborts the ramp with a sticky err.
// Ports:
//   clk        in   system clock
//   nRst       in   asynchronous active-low reset
//   start      in   one-cycle request, latches target (ignored while busy)
//   target     in   requested final duty
//   busy       out  ramp in progress
//   done       out  one-cycle pulse, target reached and confirmed
//   err        out  sticky timeout flag, cleared by the next accepted start
//   duty       out  commanded duty to the generator
//   update     out  one-cycle load strobe to the generator
//   meas_valid in   measurement strobe from the measurer
//   meas_duty  in   measured duty
module pwm_ramp
  import pwm_pkg::*;
#(
  parameter logic [7:0]  STEP    = 8'd4,
  parameter logic [7:0]  TOL     = 8'd2,
  parameter int          SKIP    = 2,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  input  logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DUTY_W-1:0] duty,
  output logic              update,
  input  logic              meas_valid,
  input  logic [DUTY_W-1:0] meas_duty
);

  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int TCW = (TIMEOUT > 24'd1) ? $clog2(TIMEOUT) : 1;

  state_t            state_reg,  state_next;
  logic [DUTY_W-1:0] duty_reg,   duty_next;
  logic [DUTY_W-1:0] tgt_reg,    tgt_next;
  logic [SKW-1:0]    skip_reg,   skip_next;
  logic              update_reg, update_next;
  logic              busy_reg,   busy_next;
  logic              done_reg,   done_next;
  logic              err_reg,    err_next;

  logic t_clr;
  logic t_en;
  logic t_tc;

  pwm_timeout #(
    .TIMEOUT (TIMEOUT),
    .CW      (TCW)
  ) u_timeout (
    .clk      (clk),
    .nRst     (nRst),
    .clr      (t_clr),
    .load     (1'b0),
    .load_val ({TCW{1'b0}}),
    .en       (t_en),
    .tc       (t_tc)
  );

  assign duty   = duty_reg;
  assign update = update_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign err    = err_reg;

  always_comb begin
    logic [DUTY_W:0] diff9;
    logic [DUTY_W:0] stepv9;
    logic [DUTY_W:0] sum9;

    state_next  = state_reg;
    duty_next   = duty_reg;
    tgt_next    = tgt_reg;
    skip_next   = skip_reg;
    update_next = 1'b0;
    done_next   = 1'b0;
    busy_next   = busy_reg;
    err_next    = err_reg;
    t_clr       = 1'b0;
    t_en        = 1'b0;
    diff9       = '0;
    stepv9      = '0;
    sum9        = '0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          tgt_next = target;
          err_next = 1'b0;
          if (target == duty_reg) begin
            done_next = 1'b1;
          end else begin
            busy_next  = 1'b1;
            state_next = ST_STEP;
          end
        end
      end

      ST_STEP: begin
        // Step size is clamped to the remaining distance, so the duty lands
        // exactly on the target and can never wrap past 0 or 255.
        diff9  = abs_diff(tgt_reg, duty_reg);
        stepv9 = (diff9 < {1'b0, STEP}) ? diff9 : {1'b0, STEP};
        if (tgt_reg > duty_reg) begin
          sum9 = {1'b0, duty_reg} + stepv9;
        end else begin
          sum9 = {1'b0, duty_reg} - stepv9;
        end
        duty_next   = sum9[DUTY_W-1:0];
        update_next = 1'b1;
        t_clr       = 1'b1;
        skip_next   = SKW'(SKIP);
        state_next  = ST_WAIT;
      end

      ST_WAIT: begin
        t_en = 1'b1;
        // Acceptance is tested before the timeout so a good sample arriving
        // on the terminal-count cycle still wins.
        if (meas_valid && (skip_reg != '0)) begin
          skip_next = skip_reg - SKW'(1);
        end else if (meas_valid &&
                     (abs_diff(meas_duty, duty_reg) <= {1'b0, TOL})) begin
          state_next = (duty_reg == tgt_reg) ? ST_DONE : ST_STEP;
        end else if (t_tc) begin
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg  <= ST_IDLE;
      duty_reg   <= '0;
      tgt_reg    <= '0;
      skip_reg   <= '0;
      update_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      duty_reg   <= duty_next;
      tgt_reg    <= tgt_next;
      skip_reg   <= skip_next;
      update_reg <= update_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

endmodule

// File: tb/tb_pwm_ramp.sv
// tb_pwm_ramp
//   Directed bench for pwm_ramp with STEP=4, TOL=2, SKIP=2, TIMEOUT=100.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_pwm_ramp;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] target = 8'd0;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] duty;
  logic       update;
  logic       meas_valid = 1'b0;
  logic [7:0] meas_duty = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int upd_base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (update) upd_cnt <= upd_cnt + 1;
  end

  pwm_ramp #(
    .STEP    (8'd4),
    .TOL     (8'd2),
    .SKIP    (2),
    .TIMEOUT (24'd100)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .start      (start),
    .target     (target),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .duty       (duty),
    .update     (update),
    .meas_valid (meas_valid),
    .meas_duty  (meas_duty)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, obs);
    end
  endtask

  // Wait (bounded) for an update strobe, then check the commanded duty.
  task automatic step_check(input string tag, input logic [7:0] exp);
    int k = 0;
    while (!update && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_update"}, {31'd0, update}, 32'd1);
    check_eq({tag, "_duty"}, {24'd0, duty}, {24'd0, exp});
  endtask

  // n consecutive measurement strobes carrying value m.
  task automatic serve(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      meas_valid = 1'b1;
      meas_duty  = m;
      @(negedge clk);
    end
    meas_valid = 1'b0;
  endtask

  // Called right after the confirming sample's edge: done must appear one
  // edge later for exactly one cycle with busy dropped and err clear.
  task automatic done_check(input string tag);
    check_eq({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_err"},  {31'd0, err},  32'd0);
    @(negedge clk);
    check_eq({tag, "_done_end"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_start(input logic [7:0] t);
    start  = 1'b1;
    target = t;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_duty",   {24'd0, duty},   32'd0);
    check_eq("rst_flags",  {28'd0, busy, done, err, update}, 32'd0);
    nRst = 1'b1;
    @(negedge clk);

    // Ramp up 0 -> 10: duties 4, 8, 10
    upd_base = upd_cnt;
    do_start(8'd10);
    check_eq("up_busy", {31'd0, busy}, 32'd1);
    check_eq("up_no_upd_yet", {31'd0, update}, 32'd0);
    @(negedge clk);
    check_eq("up_update_n1", {31'd0, update}, 32'd1);
    check_eq("up_s1_duty", {24'd0, duty}, 32'd4);
    serve(8'd4, 3);
    step_check("up_s2", 8'd8);
    serve(8'd8, 3);
    step_check("up_s3", 8'd10);
    serve(8'd10, 3);
    done_check("up");
    check_eq("up_nupd", upd_cnt - upd_base, 32'd3);

    // Ramp down 10 -> 0 with clamp: duties 6, 2, 0
    upd_base = upd_cnt;
    do_start(8'd0);
    step_check("dn_s1", 8'd6);
    serve(8'd6, 3);
    step_check("dn_s2", 8'd2);
    serve(8'd2, 3);
    step_check("dn_s3", 8'd0);
    serve(8'd0, 3);
    done_check("dn");
    check_eq("dn_nupd", upd_cnt - upd_base, 32'd3);
    check_eq("dn_final", {24'd0, duty}, 32'd0);

    // Tolerance: ramp 0 -> 136 with off-nominal measurements near the top
    upd_base = upd_cnt;
    do_start(8'd136);
    for (int d = 4; d <= 120; d += 4) begin
      step_check("tol_ramp", d[7:0]);
      serve(d[7:0], 3);
    end
    step_check("tol_124", 8'd124);
    serve(8'd124, 2);
    serve(8'd126, 1);                 // +2: accepted
    step_check("tol_128", 8'd128);
    serve(8'd128, 2);
    serve(8'd131, 1);                 // +3: ignored
    repeat (3) @(negedge clk);
    check_eq("tol_131_ignored", {30'd0, busy, update}, 32'd2);
    serve(8'd127, 1);                 // -1: accepted
    check_eq("tol_127_no_upd_yet", {31'd0, update}, 32'd0);
    @(negedge clk);
    check_eq("tol_127_upd", {31'd0, update}, 32'd1);
    check_eq("tol_132_duty", {24'd0, duty}, 32'd132);
    serve(8'd132, 2);
    serve(8'd129, 1);                 // -3: ignored
    serve(8'd130, 1);                 // -2: accepted
    step_check("tol_136", 8'd136);
    serve(8'd136, 3);
    done_check("tol");
    check_eq("tol_nupd", upd_cnt - upd_base, 32'd34);

    // Timeout: no measurements after the first update
    do_start(8'd200);
    step_check("to_s1", 8'd140);
    repeat (99) @(negedge clk);
    check_eq("to_err_99", {30'd0, err, busy}, 32'd1);
    @(negedge clk);
    check_eq("to_err_100", {30'd0, err, busy}, 32'd2);
    check_eq("to_duty_held", {24'd0, duty}, 32'd140);
    repeat (3) @(negedge clk);
    check_eq("to_err_sticky", {31'd0, err}, 32'd1);

    // Already at target (also clears err)
    upd_base = upd_cnt;
    do_start(8'd140);
    check_eq("at_done", {31'd0, done}, 32'd1);
    check_eq("at_err_clr", {31'd0, err}, 32'd0);
    check_eq("at_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("at_done_end", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check_eq("at_nupd", upd_cnt - upd_base, 32'd0);

    // start while busy is ignored
    do_start(8'd148);
    step_check("dis_s1", 8'd144);
    do_start(8'd200);
    serve(8'd144, 3);
    step_check("dis_s2", 8'd148);
    serve(8'd148, 3);
    done_check("dis");
    check_eq("dis_final", {24'd0, duty}, 32'd148);

    // Asynchronous reset mid-WAIT
    do_start(8'd160);
    step_check("rst_s1", 8'd152);
    serve(8'd152, 1);
    nRst = 1'b0;
    #1;
    check_eq("arst_duty", {24'd0, duty}, 32'd0);
    check_eq("arst_flags", {28'd0, busy, done, err, update}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    do_start(8'd0);                   // IDLE with duty 0: immediate done
    check_eq("arst_idle_done", {30'd0, done, busy}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
